// File: rtl/usart_frame_recv_pkg.sv
// Shared types and constants for the 5-byte UART frame receiver.
package usart_frame_recv_pkg;

  localparam int unsigned FRAME_BYTES = 5;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned ADR_W       = 2;
  localparam int unsigned MOD_W       = 6;
  localparam int unsigned D_W         = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } frame_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic [ADR_W-1:0] adress;
    logic [MOD_W-1:0] mod_sel;
    logic [D_W-1:0]   d;
  } frame_t;

  // Reserved bits of the address and mode-select bytes must be zero.
  function automatic logic header_ok(input logic [BYTE_W-1:0] b0, input logic [BYTE_W-1:0] b1);
    return (b0[7:2] == 6'd0) && (b1[7:6] == 2'd0);
  endfunction

endpackage

// File: rtl/usart_frame_recv_if.sv
// Serial input plus decoded frame fields and strobes of the frame receiver.
interface usart_frame_recv_if;
  import usart_frame_recv_pkg::*;

  logic             uart_rxd;
  logic [D_W-1:0]   D;
  logic [ADR_W-1:0] Adress;
  logic [MOD_W-1:0] Mod_SEL;
  logic             frame_valid;
  logic             frame_err;

  modport master (input uart_rxd, output D, Adress, Mod_SEL, frame_valid, frame_err);
  modport slave  (output uart_rxd, input D, Adress, Mod_SEL, frame_valid, frame_err);

endinterface

// File: rtl/uart_recv.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling, stop-bit framing check.
module uart_recv
  import usart_frame_recv_pkg::*;
#(
  parameter logic [CNT_W-1:0] BPS_CNT = 16'd434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              rx_done,
  output logic              rx_ferr
);

  localparam logic [CNT_W-1:0] HALF_CNT = BPS_CNT >> 1;
  localparam logic [CNT_W-1:0] LAST_CNT = BPS_CNT - 16'd1;

  rx_state_t         state, state_n;
  logic [2:0]        sync;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shreg;
  logic              rxd_s, fall;
  logic              cnt_clr, shift_c, done_c, ferr_c;

  // sync[1] is the synchronised level; sync[2] is its history for edge detection
  assign rxd_s = sync[1];
  assign fall  = sync[2] & ~sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    shift_c = 1'b0;
    done_c  = 1'b0;
    ferr_c  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (fall) begin
          state_n = RX_START;
          cnt_clr = 1'b1;
        end
      end
      RX_START: begin
        if (cnt == HALF_CNT) begin
          cnt_clr = 1'b1;
          state_n = rxd_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_clr = 1'b1;
          shift_c = 1'b1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_clr = 1'b1;
          done_c  = rxd_s;
          ferr_c  = ~rxd_s;
          state_n = RX_IDLE;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= 3'b111;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      rx_byte <= '0;
      rx_done <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      sync    <= {sync[1:0], rxd};
      cnt     <= (cnt_clr || state == RX_IDLE) ? '0 : cnt + 16'd1;
      if (state == RX_START)  bit_idx <= '0;
      else if (shift_c)       bit_idx <= bit_idx + 3'd1;
      if (shift_c) shreg <= {rxd_s, shreg[BYTE_W-1:1]};
      if (done_c)  rx_byte <= shreg;
      rx_done <= done_c;
      rx_ferr <= ferr_c;
    end
  end

endmodule

// File: rtl/usart_frame_recv.sv
// Assembles 5-byte UART frames into address/mode/data fields with valid/error strobes.
module usart_frame_recv
  import usart_frame_recv_pkg::*;
#(
  parameter logic [CNT_W-1:0] BPS_CNT = 16'd434,
  parameter logic [CNT_W-1:0] GAP_CNT = 16'd20000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  usart_frame_recv_if.master  bus
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);

  frame_state_t      state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [BYTE_W-1:0] bytes_q [FRAME_BYTES-1];
  logic [CNT_W-1:0]  gap;
  frame_t            frame_q;
  logic              valid_q, err_q;
  logic [BYTE_W-1:0] rx_byte;
  logic              rx_done, rx_ferr;
  logic              store_c, valid_c, err_c;

  uart_recv #(.BPS_CNT(BPS_CNT)) u_recv (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .rxd     (bus.uart_rxd),
    .rx_byte (rx_byte),
    .rx_done (rx_done),
    .rx_ferr (rx_ferr)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_n;
  end

  // The last byte is checked as it arrives so the strobe lands in the CHECK cycle
  always_comb begin
    state_n = state;
    idx_n   = idx;
    store_c = 1'b0;
    valid_c = 1'b0;
    err_c   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_done) begin
          store_c = 1'b1;
          idx_n   = 3'd1;
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_done) begin
          if (idx == IDX_LAST) begin
            state_n = CHECK;
            idx_n   = '0;
            if (header_ok(bytes_q[0], bytes_q[1])) valid_c = 1'b1;
            else                                   err_c   = 1'b1;
          end else begin
            store_c = 1'b1;
            idx_n   = idx + 3'd1;
          end
        end else if (rx_ferr || gap == GAP_CNT) begin
          err_c   = 1'b1;
          idx_n   = '0;
          state_n = IDLE;
        end
      end
      CHECK: begin
        idx_n   = '0;
        state_n = IDLE;
      end
      default: begin
        idx_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idx     <= '0;
      gap     <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < FRAME_BYTES - 1; i++) bytes_q[i] <= '0;
    end else begin
      idx <= idx_n;
      if (state != COLLECT || rx_done) gap <= '0;
      else if (gap != GAP_CNT)         gap <= gap + 16'd1;
      if (store_c) bytes_q[idx[1:0]] <= rx_byte;
      if (valid_c) frame_q <= {bytes_q[0][ADR_W-1:0], bytes_q[1][MOD_W-1:0],
                               bytes_q[2], bytes_q[3], rx_byte};
      valid_q <= valid_c;
      err_q   <= err_c;
    end
  end

  assign bus.D           = frame_q.d;
  assign bus.Adress      = frame_q.adress;
  assign bus.Mod_SEL     = frame_q.mod_sel;
  assign bus.frame_valid = valid_q;
  assign bus.frame_err   = err_q;

endmodule
